// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer.
package led_seq_pkg;

  localparam int unsigned TICKS_PER_STEP_DEF = 25_000_000;

  localparam logic [1:0] MODE_LEFT   = 2'd0;
  localparam logic [1:0] MODE_RIGHT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  typedef enum logic [2:0] {
    S_LEFT,
    S_RIGHT,
    S_BNC_UP,
    S_BNC_DN,
    S_BLINK
  } state_e;

  // Both bounce directions report as the single bounce mode.
  function automatic logic [1:0] state_to_mode(input state_e s);
    logic [1:0] m;
    case (s)
      S_RIGHT:            m = MODE_RIGHT;
      S_BNC_UP, S_BNC_DN: m = MODE_BOUNCE;
      S_BLINK:            m = MODE_BLINK;
      default:            m = MODE_LEFT;
    endcase
    return m;
  endfunction

  // Entry state for a newly applied mode; bounce always starts moving up.
  function automatic state_e mode_to_state(input logic [1:0] m);
    state_e s;
    case (m)
      MODE_RIGHT:  s = S_RIGHT;
      MODE_BOUNCE: s = S_BNC_UP;
      MODE_BLINK:  s = S_BLINK;
      default:     s = S_LEFT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_sequencer_step_prescaler.sv
// Step prescaler: counts clock cycles and flags the last cycle of each step period.
module step_prescaler
  import led_seq_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = TICKS_PER_STEP_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       adv
);

  localparam int unsigned CW = $clog2(TICKS_PER_STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_cnt;

  // Terminal count for the selected period; >= lets a shortened period fire at once.
  always_comb begin
    last_cnt = CW'((TICKS_PER_STEP >> speed) - 1);
    adv      = (cnt_q >= last_cnt) && !pause;
  end

  // Counter next state: restart on a step, hold while paused.
  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = '0;
    end else if (!pause) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED bank pattern sequencer with step-aligned mode change handshake.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = TICKS_PER_STEP_DEF,
  parameter int unsigned LED_W          = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [1:0]       mode_sel,
  input  logic             mode_req,
  output logic             mode_ack,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [1:0]       mode,
  output logic             step_tick,
  output logic [LED_W-1:0] LEDR
);

  localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

  logic             adv;
  state_e           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic             step_tick_q, mode_ack_q;
  logic             reload;

  step_prescaler #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .speed   (speed),
    .pause   (pause),
    .adv     (adv)
  );

  // Next state for pending request, FSM and LED pattern.
  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    // A pending request for the mode already running just acks without a reload.
    reload       = adv && pend_valid_q && (pend_mode_q != state_to_mode(state_q));

    if (adv) begin
      pend_valid_d = 1'b0;
      if (reload) begin
        state_d = mode_to_state(pend_mode_q);
        case (pend_mode_q)
          MODE_RIGHT: led_d = LED_MSB;
          MODE_BLINK: led_d = '1;
          default:    led_d = LED_LSB;
        endcase
      end else begin
        case (state_q)
          S_LEFT:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          S_RIGHT: led_d = {led_q[0], led_q[LED_W-1:1]};
          S_BNC_UP: begin
            led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            if (led_d[LED_W-1]) state_d = S_BNC_DN;
          end
          S_BNC_DN: begin
            led_d = {led_q[0], led_q[LED_W-1:1]};
            if (led_d[0]) state_d = S_BNC_UP;
          end
          S_BLINK: led_d = ~led_q;
          default: begin
            state_d = S_LEFT;
            led_d   = LED_LSB;
          end
        endcase
      end
    end

    // A request in the step cycle itself survives the clear and waits for the next step.
    if (mode_req) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_sel;
    end
  end

  // State, pattern and strobe registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_LEFT;
      led_q        <= LED_LSB;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_LEFT;
      step_tick_q  <= 1'b0;
      mode_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      step_tick_q  <= adv;
      mode_ack_q   <= adv && pend_valid_q;
    end
  end

  // Output mapping.
  always_comb begin
    mode      = state_to_mode(state_q);
    LEDR      = led_q;
    step_tick = step_tick_q;
    mode_ack  = mode_ack_q;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with TICKS_PER_STEP=8.
module tb_led_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_req = 1'b0;
  logic       mode_ack;
  logic [1:0] speed    = 2'd0;
  logic       pause    = 1'b0;
  logic [1:0] mode;
  logic       step_tick;
  logic [7:0] LEDR;

  led_sequencer #(
    .TICKS_PER_STEP(8),
    .LED_W         (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .mode_sel (mode_sel),
    .mode_req (mode_req),
    .mode_ack (mode_ack),
    .speed    (speed),
    .pause    (pause),
    .mode     (mode),
    .step_tick(step_tick),
    .LEDR     (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected step: LEDR/mode/ack values taking effect on a given edge after reset.
  typedef struct {
    int         at_edge;
    logic [7:0] led;
    logic [1:0] mode;
    logic       ack;
  } exp_t;

  // Stimulus applied just after the given edge, sampled on the next one.
  typedef struct {
    int         at;
    logic       req;
    logic [1:0] sel;
    logic       pause;
    logic [1:0] speed;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_tbl[$];

  int         n_vec  = 0;
  int         n_fail = 0;
  int         edge_n = 0;
  logic [7:0] exp_led;
  logic [1:0] exp_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, edge_n, act, expv);
    end
  endtask

  // Asynchronous reset, asserted and released away from the clock edge.
  task automatic do_reset();
    #3;
    RESET    = 1'b1;
    mode_req = 1'b0;
    mode_sel = 2'd0;
    pause    = 1'b0;
    speed    = 2'd0;
    #1;
    chk("rst_ledr", 32'(LEDR), 32'h01);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_tick", 32'(step_tick), 32'd0);
    chk("rst_ack", 32'(mode_ack), 32'd0);
    repeat (3) @(posedge CLOCK_50);
    #3;
    RESET    = 1'b0;
    edge_n   = 0;
    exp_led  = 8'h01;
    exp_mode = 2'd0;
    stim_tbl.delete();
    exp_q.delete();
  endtask

  // One clock: compare all outputs against the scoreboard, then drive stimulus.
  task automatic cycle();
    exp_t e;
    logic t, a;
    @(posedge CLOCK_50);
    #1;
    edge_n++;
    t = 1'b0;
    a = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].at_edge == edge_n) begin
      e        = exp_q.pop_front();
      exp_led  = e.led;
      exp_mode = e.mode;
      t        = 1'b1;
      a        = e.ack;
    end
    chk("ledr", 32'(LEDR), 32'(exp_led));
    chk("mode", 32'(mode), 32'(exp_mode));
    chk("step_tick", 32'(step_tick), 32'(t));
    chk("mode_ack", 32'(mode_ack), 32'(a));
    mode_req = 1'b0;
    foreach (stim_tbl[i]) begin
      if (stim_tbl[i].at == edge_n) begin
        mode_req = stim_tbl[i].req;
        mode_sel = stim_tbl[i].sel;
        pause    = stim_tbl[i].pause;
        speed    = stim_tbl[i].speed;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drained(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] bnc [16];

  initial begin
    bnc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    // Idle rotate-left, including the 80h -> 01h wrap at edge 64.
    do_reset();
    for (int k = 1; k <= 9; k++) exp_q.push_back('{8 * k, 8'(1 << (k % 8)), 2'd0, 1'b0});
    run(75);
    drained("idle_steps");

    // Bounce: each end shown for one step only.
    do_reset();
    stim_tbl.push_back('{3, 1'b1, 2'd2, 1'b0, 2'd0});
    for (int i = 0; i < 16; i++) exp_q.push_back('{8 + 8 * i, bnc[i], 2'd2, i == 0});
    run(130);
    drained("bounce_steps");

    // Last request wins; a request in the step cycle lands one step later.
    do_reset();
    stim_tbl.push_back('{2, 1'b1, 2'd1, 1'b0, 2'd0});
    stim_tbl.push_back('{5, 1'b1, 2'd3, 1'b0, 2'd0});
    stim_tbl.push_back('{15, 1'b1, 2'd0, 1'b0, 2'd0});
    exp_q.push_back('{8, 8'hFF, 2'd3, 1'b1});
    exp_q.push_back('{16, 8'h00, 2'd3, 1'b0});
    exp_q.push_back('{24, 8'h01, 2'd0, 1'b1});
    exp_q.push_back('{32, 8'h02, 2'd0, 1'b0});
    run(34);
    drained("last_wins");

    // Pause for ten cycles pushes the first step to edge 18.
    do_reset();
    stim_tbl.push_back('{3, 1'b0, 2'd0, 1'b1, 2'd0});
    stim_tbl.push_back('{13, 1'b0, 2'd0, 1'b0, 2'd0});
    exp_q.push_back('{18, 8'h02, 2'd0, 1'b0});
    exp_q.push_back('{26, 8'h04, 2'd0, 1'b0});
    run(28);
    drained("pause");

    // Speed shortened mid-count steps on the next cycle, then every 2.
    do_reset();
    stim_tbl.push_back('{5, 1'b0, 2'd0, 1'b0, 2'd2});
    exp_q.push_back('{6, 8'h02, 2'd0, 1'b0});
    exp_q.push_back('{8, 8'h04, 2'd0, 1'b0});
    exp_q.push_back('{10, 8'h08, 2'd0, 1'b0});
    exp_q.push_back('{12, 8'h10, 2'd0, 1'b0});
    run(12);
    drained("speed");

    // Mid-run reset in blink with a request pending; the request must vanish.
    do_reset();
    stim_tbl.push_back('{2, 1'b1, 2'd3, 1'b0, 2'd0});
    stim_tbl.push_back('{10, 1'b1, 2'd1, 1'b0, 2'd0});
    exp_q.push_back('{8, 8'hFF, 2'd3, 1'b1});
    run(12);
    drained("blink_entry");
    do_reset();
    exp_q.push_back('{8, 8'h02, 2'd0, 1'b0});
    exp_q.push_back('{16, 8'h04, 2'd0, 1'b0});
    run(18);
    drained("after_midrst");

    // Same-mode request in rotate-right: normal step plus ack.
    do_reset();
    stim_tbl.push_back('{2, 1'b1, 2'd1, 1'b0, 2'd0});
    stim_tbl.push_back('{34, 1'b1, 2'd1, 1'b0, 2'd0});
    exp_q.push_back('{8, 8'h80, 2'd1, 1'b1});
    exp_q.push_back('{16, 8'h40, 2'd1, 1'b0});
    exp_q.push_back('{24, 8'h20, 2'd1, 1'b0});
    exp_q.push_back('{32, 8'h10, 2'd1, 1'b0});
    exp_q.push_back('{40, 8'h08, 2'd1, 1'b1});
    exp_q.push_back('{48, 8'h04, 2'd1, 1'b0});
    run(50);
    drained("same_mode");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
